// File: rtl/lcd_display_if.sv
// Pin-level bundle between the LCD driver and the panel, plus the packed message input.
// The frame_done strobe exists only when LCD_FRAME_DONE_EN is defined.
interface lcd_display_if;
    logic [255:0] message_in;
    logic         lcd_rs;
    logic         lcd_rw;
    logic         lcd_en;
    logic [7:0]   lcd_data;
`ifdef LCD_FRAME_DONE_EN
    logic         frame_done;

    modport master (
        input  message_in,
        output lcd_rs, lcd_rw, lcd_en, lcd_data, frame_done
    );

    modport slave (
        output message_in,
        input  lcd_rs, lcd_rw, lcd_en, lcd_data, frame_done
    );
`else
    modport master (
        input  message_in,
        output lcd_rs, lcd_rw, lcd_en, lcd_data
    );

    modport slave (
        output message_in,
        input  lcd_rs, lcd_rw, lcd_en, lcd_data
    );
`endif
endinterface

// File: rtl/lcd_display.sv
// HD44780 16x2 write-only driver: power-on wait, 4-command init, then endless two-row refresh.
// Optional frame_done strobe is enabled by defining LCD_FRAME_DONE_EN.
module lcd_display #(
    parameter int STEP_CYCLES  = 8,
    parameter int CLEAR_CYCLES = 32,
    parameter int POWER_CYCLES = 16
) (
    input  logic          clock,
    input  logic          reset,
    lcd_display_if.master bus
);

    localparam int MAX_CYCLES = (POWER_CYCLES > CLEAR_CYCLES) ? POWER_CYCLES : CLEAR_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] HALF_STEP  = CNT_W'(STEP_CYCLES / 2);
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(STEP_CYCLES - 2);
    localparam logic [5:0]       ROW2_IDX   = 6'd17;
    localparam logic [5:0]       LAST_IDX   = 6'd33;

    typedef enum logic [1:0] {
        POWER_WAIT,
        INIT,
        FRAME
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cur_len;
    logic [5:0]       idx;
    logic [5:0]       next_idx;
    logic [4:0]       char_k;
    logic [7:0]       char_byte;
    logic [255:0]     msg_buf;
    logic             last_cycle;
    logic             rs_q;
    logic             en_q;
    logic [7:0]       data_q;
    logic             fd_q;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction

    // Frame step 0 is the row-1 address, 17 the row-2 address; the rest map onto characters.
    always_comb begin
        cur_len = CNT_W'(STEP_CYCLES);
        if (state == POWER_WAIT)
            cur_len = CNT_W'(POWER_CYCLES);
        else if (state == INIT && idx == 6'd2)
            cur_len = CNT_W'(CLEAR_CYCLES);
        next_idx  = idx + 6'd1;
        char_k    = (next_idx < ROW2_IDX) ? 5'(next_idx - 6'd1) : 5'(next_idx - 6'd2);
        char_byte = msg_buf[{char_k, 3'b000} +: 8];
    end

    assign last_cycle = (cnt == cur_len - CNT_W'(1));

    // rs/data are loaded only at counter wrap, so they stay put for a whole transfer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= POWER_WAIT;
            cnt     <= '0;
            idx     <= '0;
            msg_buf <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= 8'h00;
            fd_q    <= 1'b0;
        end else begin
            en_q <= (state != POWER_WAIT) && !last_cycle && (cnt < HALF_STEP);
            fd_q <= (state == FRAME) && (idx == LAST_IDX) && (cnt == PRE_LAST);
            if (!last_cycle) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
                case (state)
                    POWER_WAIT: begin
                        state  <= INIT;
                        idx    <= '0;
                        rs_q   <= 1'b0;
                        data_q <= init_cmd(2'd0);
                    end
                    INIT: begin
                        if (idx == 6'd3) begin
                            state   <= FRAME;
                            idx     <= '0;
                            rs_q    <= 1'b0;
                            data_q  <= 8'h80;
                            msg_buf <= bus.message_in;
                        end else begin
                            idx    <= next_idx;
                            rs_q   <= 1'b0;
                            data_q <= init_cmd(next_idx[1:0]);
                        end
                    end
                    FRAME: begin
                        if (idx == LAST_IDX) begin
                            idx     <= '0;
                            rs_q    <= 1'b0;
                            data_q  <= 8'h80;
                            msg_buf <= bus.message_in;
                        end else if (next_idx == ROW2_IDX) begin
                            idx    <= next_idx;
                            rs_q   <= 1'b0;
                            data_q <= 8'hC0;
                        end else begin
                            idx    <= next_idx;
                            rs_q   <= 1'b1;
                            data_q <= char_byte;
                        end
                    end
                    default: state <= POWER_WAIT;
                endcase
            end
        end
    end

    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_en   = en_q;
    assign bus.lcd_data = data_q;

`ifdef LCD_FRAME_DONE_EN
    assign bus.frame_done = fd_q;
`else
    logic unused_fd;
    assign unused_fd = fd_q;
`endif

endmodule

// File: tb/tb_lcd_display.sv
// Randomized bench for lcd_display: a per-cycle expected pin trace is built from the transfer list.
// Covers reset idle, init, frame contents, message latching, async reset and frame period.
module tb_lcd_display;

    localparam int STEP  = 8;
    localparam int CLEAR = 32;
    localparam int POWER = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;

    lcd_display_if bus ();

    lcd_display #(
        .STEP_CYCLES (STEP),
        .CLEAR_CYCLES(CLEAR),
        .POWER_CYCLES(POWER)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [11:0] exp_q[$];
    bit          init_done;
    int          cycle;
    int          last80;
    int          since80;
    int          frames;
    bit          prev_is80;
    bit          forced_done;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cycle, got, expv);
        end
    endtask

    // {frame_done, rs, rw, en, data}
    function automatic logic [11:0] observed();
        logic fd;
`ifdef LCD_FRAME_DONE_EN
        fd = bus.frame_done;
`else
        fd = 1'b0;
`endif
        return {fd, bus.lcd_rs, bus.lcd_rw, bus.lcd_en, bus.lcd_data};
    endfunction

    task automatic apply_stimulus(input logic [255:0] msg);
        bus.message_in = msg;
    endtask

    task automatic apply_random_message();
        logic [255:0] m;
        for (int k = 0; k < 32; k++) m[8*k +: 8] = 8'($urandom_range(0, 255));
        apply_stimulus(m);
    endtask

    task automatic push_transfer(input bit rs, input logic [7:0] b, input int len, input bit last);
        bit en;
        bit fd;
        for (int i = 0; i < len; i++) begin
            en = (i >= 1) && (i <= STEP / 2);
`ifdef LCD_FRAME_DONE_EN
            fd = last && (i == len - 1);
`else
            fd = 1'b0;
`endif
            exp_q.push_back({fd, rs, 1'b0, en, b});
        end
    endtask

    // Either the whole power-up/init sequence or one complete frame of the current message.
    task automatic refill();
        logic [255:0] m;
        if (!init_done) begin
            for (int i = 0; i < POWER; i++) exp_q.push_back(12'h000);
            push_transfer(1'b0, 8'h38, STEP, 1'b0);
            push_transfer(1'b0, 8'h0C, STEP, 1'b0);
            push_transfer(1'b0, 8'h01, CLEAR, 1'b0);
            push_transfer(1'b0, 8'h06, STEP, 1'b0);
            init_done = 1'b1;
        end else begin
            m = bus.message_in;
            push_transfer(1'b0, 8'h80, STEP, 1'b0);
            for (int k = 0; k < 16; k++) push_transfer(1'b1, m[8*k +: 8], STEP, 1'b0);
            push_transfer(1'b0, 8'hC0, STEP, 1'b0);
            for (int k = 16; k < 32; k++) push_transfer(1'b1, m[8*k +: 8], STEP, k == 31);
        end
    endtask

    task automatic restart_model();
        exp_q.delete();
        init_done   = 1'b0;
        cycle       = 0;
        last80      = -1;
        since80     = 0;
        frames      = 0;
        prev_is80   = 1'b0;
        forced_done = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        logic [11:0] expv;
        logic [11:0] obs;
        bit          is80;
        for (int c = 0; c < n; c++) begin
            if (exp_q.size() == 0) refill();
            expv = exp_q.pop_front();
            obs  = observed();
            check_output("lcd_bus", 32'(obs), 32'(expv));
            is80 = (obs[10] == 1'b0) && (obs[7:0] == 8'h80);
            if (is80 && !prev_is80) begin
                if (last80 >= 0) check_output("frame_period", 32'(cycle - last80), 32'(34 * STEP));
                last80  = cycle;
                frames++;
                since80 = 0;
            end
            prev_is80 = is80;
            since80++;
            if (frames == 2 && since80 == 5 * STEP && !forced_done) begin
                apply_random_message();
                forced_done = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                apply_random_message();
            end
            cycle++;
            @(negedge clock);
        end
    endtask

    initial begin
        string        txt;
        logic [255:0] m;

        txt = "NS:9831 SN:4297 EW:1245 WE:2321 ";
        for (int k = 0; k < 32; k++) m[8*k +: 8] = txt[k];
        apply_stimulus(m);
        restart_model();

        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check_output("reset_idle", 32'(observed()), 32'h0);
        end

        reset = 1'b1;
        run_cycles(80 + 272 * 5 + 100);

        #2 reset = 1'b0;
        #1 check_output("async_reset", 32'(observed()), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_output("reset_hold", 32'(observed()), 32'h0);
        end

        apply_random_message();
        restart_model();
        reset = 1'b1;
        run_cycles(80 + 272 * 3 + 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_display.md
Name: lcd_display

Overview:
- Drives a 16x2 HD44780-compatible character LCD over an 8-bit parallel bus (write-only).
- Shows a 32-character ASCII message in two rows of 16.
- Performs a one-time init sequence after reset, then refreshes both rows continuously from message_in.
- Sits between upstream formatting logic (which packs ASCII text into message_in) and the LCD pins.

Parameters:
- STEP_CYCLES, 8, clock cycles per ordinary LCD transfer (even, >=4).
- CLEAR_CYCLES, 32, clock cycles for the clear-display command (0x01), >= STEP_CYCLES.
- POWER_CYCLES, 16, power-on wait in clocks before the first init command.
- Hardware builds override all three from clock frequency; defaults are for simulation.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- message_in  input  256  32 ASCII chars; char k = message_in[8k+7:8k].
  - k=0..15 → row 1, columns 0..15.
  - k=16..31 → row 2, columns 0..15.
- lcd_rs  output  1  0 = command, 1 = data.
- lcd_rw  output  1  always 0 (write-only).
- lcd_en  output  1  LCD enable strobe.
- lcd_data  output  8  LCD data bus.

Behaviour:
- Reset (reset=0, async assert, sync release):
  - lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data=8'h00.
  - Internal counters zero; FSM in POWER_WAIT.
- Reset mid-operation aborts immediately; after release the full init sequence reruns.
- FSM states: POWER_WAIT → INIT → FRAME → FRAME, forever.
  - POWER_WAIT: outputs idle for POWER_CYCLES clocks.
  - INIT: commands in order 0x38 (8-bit, 2 lines, 5x8), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry increment, no shift).
  - FRAME, 34 transfers in order:
    - cmd 0x80;
    - data chars 0..15;
    - cmd 0xC0;
    - data chars 16..31.
  - After the last char the FSM starts the next FRAME immediately.
- Transfer timing:
  - A transfer occupies STEP_CYCLES clocks (CLEAR_CYCLES for 0x01). A step counter runs 0..N-1.
  - lcd_rs and lcd_data are stable for the whole transfer.
  - lcd_en=1 only while counter is in 1..STEP_CYCLES/2, giving setup before the rising edge and hold after the falling edge.
  - The next transfer's rs/data change only at counter wrap.
  - Outputs are registered.
- Message latching:
  - message_in is sampled into an internal 256-bit buffer on the first clock of each FRAME (the 0x80 step).
  - Changes to message_in mid-frame appear only in the next frame; no tearing within a frame.
- Characters are passed unmodified; no ASCII validation.
- Latency:
  - First data byte of frame 1 is presented at clock POWER_CYCLES + 3*STEP_CYCLES + CLEAR_CYCLES + STEP_CYCLES after reset release.
  - Frame period = 34*STEP_CYCLES.

Optional Feature:
- Macro LCD_FRAME_DONE_EN.
- When defined:
  - Adds output frame_done (1 bit).
  - frame_done pulses high for exactly one clock on the last cycle of each FRAME's final transfer (char 31).
  - Reset value 0.
- When undefined: port absent; behaviour otherwise identical.

Test Plan:
- Hold reset=0 for 20 clocks → lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00 throughout.
- Release reset with defaults:
  - 16 idle clocks.
  - Then lcd_data 0x38, 0x0C, 0x01, 0x06 with lcd_rs=0.
  - Exactly one lcd_en pulse of 4 clocks per command; 0x01 lasts 32 clocks.
- message_in = "NS:9831 SN:4297 EW:1245 WE:2321 " (char 0 = 'N' at [7:0]):
  - Cmd 0x80, then row-1 data bytes with lcd_rs=1: 'N','S',':','9','8','3','1',' ','S','N',':','4','2','9','7',' '.
  - Cmd 0xC0, then row 2: 'E','W',':','1','2','4','5',' ','W','E',':','2','3','2','1',' '.
- Change message_in during row 1 of a frame → current frame still shows the old text; the next frame's 0x80 step latches and shows the new text.
- Assert reset=0 mid-frame:
  - Outputs go to reset values asynchronously, the same cycle.
  - After release the sequence restarts at POWER_WAIT and INIT.
- Check the frame period is 272 clocks between successive 0x80 commands.
  - With LCD_FRAME_DONE_EN, also check a single-cycle frame_done per frame, aligned to the end of the char 31 transfer.
